// File: rtl/axis_capture_pkg.sv
// axis_capture_pkg: shared types and LFSR helper
// for the AXI4-Stream capture sink.
package axis_capture_pkg;

  localparam int LFSR_WIDTH     = 16;
  localparam int CHECKSUM_WIDTH = 32;

  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    CAPTURE,
    DONE
  } capture_state_t;

  // Fibonacci step, shift left, feedback into bit 0
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
    input logic [LFSR_WIDTH-1:0] s
  );
    return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_if.sv
// axis_if: minimal AXI4-Stream bundle
// (tdata/tvalid/tready) with master/slave views.
interface axis_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, loads seed on
// reset and steps while en is high.
module lfsr16
  import axis_capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] state
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= seed;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/axis_capture_sink.sv
// axis_capture_sink: AXI4-Stream sink that captures
// LIMIT+1 beats into RAM with count and checksum.
module axis_capture_sink
  import axis_capture_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    LIMIT      = (1 << ADDR_WIDTH) - 1,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      resetn,
  axis_if.slave                     in,
  input  logic                      throttle_en,
  input  logic                      restart,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [ADDR_WIDTH:0]       beat_count,
  output logic [CHECKSUM_WIDTH-1:0] checksum,
  output logic                      done
);

  if (SEED == '0 || LIMIT > (1 << ADDR_WIDTH) - 1) begin : g_bad_cfg
    $fatal(1, "axis_capture_sink: SEED zero or LIMIT too big");
  end

  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(LIMIT);
  localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH + 1)'(1);

  capture_state_t state_q, state_d;

  logic                  tready_q, tready_d;
  logic                  accept, wr_en, last;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_n;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_q == CAPTURE),
    .seed   (SEED),
    .state  (lfsr_q)
  );

  assign lfsr_n    = lfsr_step(lfsr_q);
  assign in.tready = tready_q;
  assign accept    = in.tvalid && tready_q;
  assign wr_en     = accept && !restart;
  assign last      = beat_count == LAST;

  always_comb begin
    state_d  = state_q;
    tready_d = 1'b0;
    unique case (state_q)
      CAPTURE: begin
        if (restart) begin
          state_d = CAPTURE;
        end else if (accept && last) begin
          state_d = DONE;
        end else begin
          tready_d = throttle_en ? |lfsr_n[1:0] : 1'b1;
        end
      end
      DONE: begin
        if (restart) state_d = CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CAPTURE;
      tready_q   <= 1'b0;
      beat_count <= '0;
      checksum   <= '0;
      done       <= 1'b0;
      rd_data    <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      rd_data  <= mem[rd_addr];
      if (restart) begin
        beat_count <= '0;
        checksum   <= '0;
        done       <= 1'b0;
      end else if (wr_en) begin
        beat_count <= beat_count + ONE;
        checksum   <= checksum + CHECKSUM_WIDTH'(in.tdata);
        if (last) done <= 1'b1;
      end
    end
  end

  // capture RAM is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[beat_count[ADDR_WIDTH-1:0]] <= in.tdata;
  end

endmodule
